// File: rtl/gp_timer.sv
// General-purpose timer: prescaler, auto-reload up/down counter with one-shot mode,
// and N compare channels producing match pulses and PWM levels.
module gp_timer #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 16,
    parameter int N_CH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   load,
    input  logic                   dir,
    input  logic                   one_shot,
    input  logic [PSC_W-1:0]       psc,
    input  logic [CNT_W-1:0]       arr,
    input  logic [N_CH*CNT_W-1:0]  ccr,
    output logic [CNT_W-1:0]       cnt,
    output logic                   update_irq,
    output logic [N_CH-1:0]        cc_irq,
    output logic [N_CH-1:0]        pwm_out,
    output logic                   halted
);

    logic [PSC_W-1:0] pc;
    logic [PSC_W-1:0] psc_sh;
    logic [CNT_W-1:0] arr_sh;
    logic             tick;
    logic             upd;
    logic [CNT_W-1:0] cnt_nx;
    logic [N_CH-1:0]  cc_nx;
    logic [N_CH-1:0]  pwm_nx;

    always_comb begin
        tick   = en && !halted && !load && (pc == psc_sh);
        cnt_nx = cnt;
        upd    = 1'b0;
        if (load) begin
            cnt_nx = dir ? arr : '0;
        end else if (tick) begin
            if (!dir) begin
                // A counter above arr_sh simply runs on and wraps silently at 2^CNT_W.
                if (cnt == arr_sh) begin
                    cnt_nx = '0;
                    upd    = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end else begin
                if (cnt == '0) begin
                    cnt_nx = arr;
                    upd    = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            cc_nx[i]  = tick && (cnt_nx == ccr[i*CNT_W +: CNT_W]);
            pwm_nx[i] = cnt_nx < ccr[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            psc_sh     <= '0;
            arr_sh     <= '0;
            cnt        <= '0;
            update_irq <= 1'b0;
            cc_irq     <= '0;
            pwm_out    <= '0;
            halted     <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            update_irq <= upd;
            cc_irq     <= cc_nx;
            pwm_out    <= pwm_nx;
            if (load) begin
                pc     <= '0;
                psc_sh <= psc;
                arr_sh <= arr;
                halted <= 1'b0;
            end else begin
                if (en && !halted)
                    pc <= tick ? '0 : pc + PSC_W'(1);
                // Shadows only change at a period boundary, never mid-period.
                if (upd) begin
                    psc_sh <= psc;
                    arr_sh <= arr;
                end
                if (!en)
                    halted <= 1'b0;
                else if (upd && one_shot)
                    halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gp_timer.sv
// Self-checking bench for gp_timer: directed vector table, corner-case sequences,
// and randomized traffic against a cycle-level reference model.
module tb_gp_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, load = 1'b0, dir = 1'b0, one_shot = 1'b0;
    logic [15:0] psc = '0, arr = '0;
    logic [31:0] ccr = '0;
    logic [15:0] cnt;
    logic        update_irq, halted;
    logic [1:0]  cc_irq, pwm_out;

    gp_timer #(.CNT_W(16), .PSC_W(16), .N_CH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .dir(dir), .one_shot(one_shot),
        .psc(psc), .arr(arr), .ccr(ccr), .cnt(cnt), .update_irq(update_irq),
        .cc_irq(cc_irq), .pwm_out(pwm_out), .halted(halted)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] outs();
        return {halted, pwm_out, cc_irq, update_irq, cnt};
    endfunction

    typedef struct {
        logic        en, load, dir;
        logic [15:0] e_cnt;
        logic        e_upd;
        logic [1:0]  e_cc, e_pwm;
        logic        e_halt;
    } vec_t;

    // Reference model state (tick countdown formulation)
    int m_cnt, m_psc, m_arr, m_rem;
    bit m_halt, m_upd;
    bit [1:0] m_cc, m_pwm;

    task automatic model_step();
        int ch;
        bit t;
        m_upd = 0;
        m_cc  = '0;
        if (load) begin
            m_cnt  = dir ? int'(arr) : 0;
            m_psc  = int'(psc);
            m_arr  = int'(arr);
            m_rem  = m_psc + 1;
            m_halt = 0;
        end else begin
            t = 0;
            if (en && !m_halt) begin
                m_rem--;
                t = (m_rem == 0);
            end
            if (t) begin
                if (!dir) begin
                    if (m_cnt == m_arr) begin m_cnt = 0; m_upd = 1; end
                    else m_cnt = (m_cnt + 1) % 65536;
                end else begin
                    if (m_cnt == 0) begin m_cnt = int'(arr); m_upd = 1; end
                    else m_cnt = m_cnt - 1;
                end
                if (m_upd) begin
                    m_psc = int'(psc);
                    m_arr = int'(arr);
                    if (one_shot) m_halt = 1;
                end
                m_rem = m_psc + 1;
                for (int i = 0; i < 2; i++) begin
                    ch = int'(ccr[i*16 +: 16]);
                    m_cc[i] = (m_cnt == ch);
                end
            end
            if (!en) m_halt = 0;
        end
        for (int i = 0; i < 2; i++) begin
            ch = int'(ccr[i*16 +: 16]);
            m_pwm[i] = (m_cnt < ch);
        end
    endtask

    initial begin
        vec_t tbl[13];
        int n, k, mx, upds, p0, p1, c0, c1;
        bit found;

        // psc=0, arr=3, ccr0=2, ccr1=5
        tbl[0]  = '{1, 1, 0, 16'd0, 0, 2'b00, 2'b11, 0};
        tbl[1]  = '{1, 0, 0, 16'd1, 0, 2'b00, 2'b11, 0};
        tbl[2]  = '{1, 0, 0, 16'd2, 0, 2'b01, 2'b10, 0};
        tbl[3]  = '{1, 0, 0, 16'd3, 0, 2'b00, 2'b10, 0};
        tbl[4]  = '{1, 0, 0, 16'd0, 1, 2'b00, 2'b11, 0};
        tbl[5]  = '{1, 0, 0, 16'd1, 0, 2'b00, 2'b11, 0};
        tbl[6]  = '{1, 0, 0, 16'd2, 0, 2'b01, 2'b10, 0};
        tbl[7]  = '{0, 0, 0, 16'd2, 0, 2'b00, 2'b10, 0};
        tbl[8]  = '{1, 0, 0, 16'd3, 0, 2'b00, 2'b10, 0};
        tbl[9]  = '{1, 0, 1, 16'd2, 0, 2'b01, 2'b10, 0};
        tbl[10] = '{1, 0, 1, 16'd1, 0, 2'b00, 2'b11, 0};
        tbl[11] = '{1, 0, 1, 16'd0, 0, 2'b00, 2'b11, 0};
        tbl[12] = '{1, 0, 1, 16'd3, 1, 2'b00, 2'b10, 0};

        #12;
        chk("reset_state", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_release", 32'(outs()), 32'd0);

        psc = 16'd0; arr = 16'd3; ccr = {16'd5, 16'd2}; one_shot = 1'b0;
        for (int i = 0; i < 13; i++) begin
            en = tbl[i].en; load = tbl[i].load; dir = tbl[i].dir;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].e_halt, tbl[i].e_pwm, tbl[i].e_cc, tbl[i].e_upd, tbl[i].e_cnt}));
        end

        // Down count, psc=2, arr=4: 15-cycle period
        en = 1; dir = 1; psc = 16'd2; arr = 16'd4; load = 1;
        step();
        load = 0;
        chk("down_load_cnt", 32'(cnt), 32'd4);
        n = 0; found = 0;
        for (k = 1; k <= 40 && !found; k++) begin
            step();
            if (update_irq) begin found = 1; n = k; end
        end
        chk("down_first_upd_cycles", 32'(n), 32'd15);
        chk("down_reload_cnt", 32'(cnt), 32'd4);
        n = 0; found = 0;
        for (k = 1; k <= 40 && !found; k++) begin
            step();
            if (update_irq) begin found = 1; n = k; end
        end
        chk("down_period", 32'(n), 32'd15);

        // One-shot, arr=5
        dir = 0; psc = 0; arr = 16'd5; one_shot = 1; load = 1;
        step();
        load = 0;
        upds = 0;
        for (k = 0; k < 15; k++) begin
            step();
            if (update_irq) upds++;
        end
        chk("oneshot_upd_count", 32'(upds), 32'd1);
        chk("oneshot_halted", 32'(halted), 32'd1);
        chk("oneshot_cnt_hold", 32'(cnt), 32'd0);
        en = 0;
        step();
        chk("oneshot_en_low_clears", 32'(halted), 32'd0);
        en = 1;
        step();
        chk("oneshot_resume_cnt", 32'(cnt), 32'd1);
        one_shot = 0;

        // arr lowered 9 -> 2 mid-period at cnt=5
        arr = 16'd9; ccr = '0; load = 1;
        step();
        load = 0;
        for (k = 0; k < 5; k++) step();
        chk("arrchg_cnt5", 32'(cnt), 32'd5);
        arr = 16'd2;
        n = 0; mx = 0; found = 0;
        for (k = 1; k <= 20 && !found; k++) begin
            step();
            if (int'(cnt) > mx) mx = int'(cnt);
            if (update_irq) begin found = 1; n = k; end
        end
        chk("arrchg_old_period_end", 32'(n), 32'd5);
        chk("arrchg_old_max", 32'(mx), 32'd9);
        n = 0; found = 0;
        for (k = 1; k <= 20 && !found; k++) begin
            step();
            if (update_irq) begin found = 1; n = k; end
        end
        chk("arrchg_new_period", 32'(n), 32'd3);

        // Compare / PWM: arr=9, ccr0=3, ccr1=12
        arr = 16'd9; ccr = {16'd12, 16'd3}; load = 1;
        step();
        load = 0;
        p0 = 0; p1 = 0; c0 = 0; c1 = 0;
        for (k = 0; k < 20; k++) begin
            step();
            p0 += int'(pwm_out[0]); p1 += int'(pwm_out[1]);
            c0 += int'(cc_irq[0]);  c1 += int'(cc_irq[1]);
        end
        chk("pwm0_high", 32'(p0), 32'd6);
        chk("pwm1_high", 32'(p1), 32'd20);
        chk("cc0_pulses", 32'(c0), 32'd2);
        chk("cc1_pulses", 32'(c1), 32'd0);

        // Randomized traffic against the model
        load = 1; en = 1; dir = 0; psc = 16'd1; arr = 16'd5; ccr = {16'd2, 16'd4};
        for (int i = 0; i < 400; i++) begin
            model_step();
            step();
            chk($sformatf("rand%0d", i), 32'(outs()),
                32'({m_halt, m_pwm, m_cc, m_upd, 16'(m_cnt)}));
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 24) == 0);
            one_shot = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            psc = 16'($urandom_range(0, 3));
            arr = 16'($urandom_range(0, 7));
            ccr = {16'($urandom_range(0, 9)), 16'($urandom_range(0, 9))};
        end

        // Asynchronous reset mid-count
        en = 1; load = 1; dir = 0; psc = 0; arr = 16'd9; ccr = {16'd12, 16'd3}; one_shot = 0;
        step();
        load = 0;
        for (k = 0; k < 4; k++) step();
        chk("pre_reset_counting", 32'(cnt), 32'd4);
        #2 rst = 1;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'd0);
        step();
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
